// File: rtl/button_pkg.sv
// Shared types and helpers for the pushbutton debouncer.
package button_pkg;

  // Debouncer FSM states
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    LONG_HELD    = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_t;

  // Number of clock cycles in a window of ms milliseconds at clk_hz
  function automatic int unsigned cycles(input int unsigned ms, input int unsigned clk_hz);
    return (clk_hz / 32'd1000) * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops; reset parks both at RST_VAL
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce_fsm.sv
// Pushbutton debouncer with press/release/long-press pulses and an LED toggle.
module button_debounce_fsm
  import button_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 27000000,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 1000,
  parameter bit          ACTIVE_HIGH   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic toggle
);

  localparam int unsigned DEB_CYC  = cycles(DEBOUNCE_MS, CLK_HZ);
  localparam int unsigned LONG_CYC = cycles(LONG_PRESS_MS, CLK_HZ);
  localparam int unsigned CNT_W    = $clog2(LONG_CYC + 1);

  // Terminal counts: debounce window, and remaining hold time once PRESSED
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - DEB_CYC - 1);

  // Refuse to build with a window too short to debounce or a long press inside it
  generate
    if (DEB_CYC < 2 || LONG_CYC <= DEB_CYC) begin : g_bad_timing
      $error("button_debounce_fsm: need DEB_CYC >= 2 and LONG_CYC > DEB_CYC");
    end
  endgenerate

  logic             btn_sync;
  logic             btn_s;
  state_t           state, state_n, prev_state;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             long_fired, long_fired_n;
  logic             level_c, press_c, release_c, long_c;

  // Synchronizer rests at the released pin level so reset looks like "not pressed"
  sync_2ff #(
    .RST_VAL (~ACTIVE_HIGH)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_sync)
  );

  assign btn_s = ACTIVE_HIGH ? btn_sync : ~btn_sync;

  // State, counter, long-press flag and previous state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      prev_state <= IDLE;
      cnt        <= '0;
      long_fired <= 1'b0;
    end else begin
      state      <= state_n;
      prev_state <= state;
      cnt        <= cnt_n;
      long_fired <= long_fired_n;
    end
  end

  // Next-state, counter update and entry-event decode
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    long_fired_n = long_fired;
    level_c      = 1'b0;
    press_c      = 1'b0;
    release_c    = 1'b0;
    long_c       = 1'b0;

    case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end
      end

      PRESS_WAIT: begin
        if (!btn_s) begin
          state_n = IDLE;
        end else if (cnt == DEB_LAST) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      PRESSED: begin
        if (!btn_s) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end else if (cnt == LONG_LAST) begin
          state_n      = LONG_HELD;
          long_fired_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      LONG_HELD: begin
        // Counter holds here so it can never wrap on a very long hold
        if (!btn_s) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end
      end

      RELEASE_WAIT: begin
        if (btn_s) begin
          // Release bounce: resume where we were, restarting the hold timer if no long yet
          if (long_fired) begin
            state_n = LONG_HELD;
          end else begin
            state_n = PRESSED;
            cnt_n   = '0;
          end
        end else if (cnt == DEB_LAST) begin
          state_n      = IDLE;
          long_fired_n = 1'b0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_n      = IDLE;
        cnt_n        = '0;
        long_fired_n = 1'b0;
      end
    endcase

    level_c   = (state == PRESSED) || (state == LONG_HELD) || (state == RELEASE_WAIT);
    press_c   = (state == PRESSED)   && (prev_state == PRESS_WAIT);
    long_c    = (state == LONG_HELD) && (prev_state == PRESSED);
    release_c = (state == IDLE)      && (prev_state == RELEASE_WAIT);
  end

  // Registered outputs; toggle flips on the edge that raises press_pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      toggle        <= 1'b0;
    end else begin
      btn_level     <= level_c;
      press_pulse   <= press_c;
      release_pulse <= release_c;
      long_pulse    <= long_c;
      toggle        <= toggle ^ press_c;
    end
  end

endmodule

// File: tb/tb_button_debounce_fsm.sv
// Directed bench for button_debounce_fsm: both polarities, bounce, long press, reset.
module tb_button_debounce_fsm;
  import button_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic btn_h, btn_l;
  logic lvl_h, prs_h, rel_h, lng_h, tog_h;
  logic lvl_l, prs_l, rel_l, lng_l, tog_l;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  button_debounce_fsm #(
    .CLK_HZ        (1000),
    .DEBOUNCE_MS   (4),
    .LONG_PRESS_MS (10),
    .ACTIVE_HIGH   (1'b1)
  ) dut_h (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_h),
    .btn_level     (lvl_h),
    .press_pulse   (prs_h),
    .release_pulse (rel_h),
    .long_pulse    (lng_h),
    .toggle        (tog_h)
  );

  button_debounce_fsm #(
    .CLK_HZ        (1000),
    .DEBOUNCE_MS   (4),
    .LONG_PRESS_MS (10),
    .ACTIVE_HIGH   (1'b0)
  ) dut_l (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_l),
    .btn_level     (lvl_l),
    .press_pulse   (prs_l),
    .release_pulse (rel_l),
    .long_pulse    (lng_l),
    .toggle        (tog_l)
  );

  // {btn_level, press_pulse, release_pulse, long_pulse, toggle}
  function automatic logic [4:0] outs(input bit low);
    return low ? {lvl_l, prs_l, rel_l, lng_l, tog_l} : {lvl_h, prs_h, rel_h, lng_h, tog_h};
  endfunction

  // Expected outputs c cycles after the pin went active (c=press_at is edge N+7)
  function automatic logic [4:0] expv(input int c, input int press_at, input int long_at,
                                      input int rel_at, input logic tog0);
    logic tog;
    tog = (c >= press_at) ? ~tog0 : tog0;
    return {(c >= press_at && c < rel_at), (c == press_at), (c == rel_at), (c == long_at), tog};
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Single clean press held for 'hold' cycles (0 = keep holding), checked every cycle
  task automatic run_press(input string name, input bit low, input int hold, input int ncyc,
                           input int press_at, input int long_at, input int rel_at,
                           input logic tog0);
    if (low) btn_l = 1'b0; else btn_h = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      chk($sformatf("%s_c%0d", name, c), outs(low), expv(c, press_at, long_at, rel_at, tog0));
      if (c == hold) begin
        if (low) btn_l = 1'b1; else btn_h = 1'b0;
      end
    end
  endtask

  initial begin
    logic [3:0] bounce;
    bounce = 4'b0101;

    // Reset state
    rst   = 1'b0;
    btn_h = 1'b0;
    btn_l = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_h", outs(1'b0), 5'b00000);
    chk("reset_l", outs(1'b1), 5'b00000);
    chk("reset_state", 5'(dut_h.state), 5'(IDLE));
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_h", outs(1'b0), 5'b00000);

    // Clean 10-cycle press: longest hold that must not produce a long pulse
    run_press("clean", 1'b0, 10, 22, 8, 0, 18, 1'b0);

    // Single-cycle glitches are rejected
    for (int i = 0; i < 16; i++) begin
      btn_h = (i < 4) ? bounce[i] : 1'b0;
      @(negedge clk);
      chk($sformatf("bounce_c%0d", i), outs(1'b0), 5'b00001);
    end
    chk("bounce_state", 5'(dut_h.state), 5'(IDLE));

    // 30-cycle hold: press, long pulse 6 cycles later, release
    run_press("hold", 1'b0, 30, 40, 8, 14, 38, 1'b1);

    // Release bounce after a long press: 0,0,1 then 0 -> back to LONG_HELD, one release
    btn_h = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      chk($sformatf("relb_c%0d", c), outs(1'b0), expv(c, 8, 14, 31, 1'b0));
      if (c == 20 || c == 23) btn_h = 1'b0;
      if (c == 22) btn_h = 1'b1;
    end

    // Reset mid-PRESSED clears outputs at once
    run_press("rst_pre", 1'b0, 0, 10, 8, 0, 99, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_h", outs(1'b0), 5'b00000);
    chk("rst_async_l", outs(1'b1), 5'b00000);
    chk("rst_async_state", 5'(dut_h.state), 5'(IDLE));
    @(negedge clk);
    chk("rst_held_h", outs(1'b0), 5'b00000);
    @(negedge clk);
    rst = 1'b1;
    // Button still held: full debounce window runs again
    run_press("rst_post", 1'b0, 10, 22, 8, 0, 18, 1'b0);

    // Active-low button behaves identically
    run_press("act_low", 1'b1, 10, 22, 8, 0, 18, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
